// File: rtl/disp_sr_par.sv
// disp_sr_par: multi-chain serial display driver.
// Shifts a captured frame out on CHAINS parallel data lines that share one
// shift clock and one latch strobe. A frame can be started by the pps strobe,
// the ppms strobe or a change of the display data. A free-running PWM counter
// on the microsecond strobe drives the blanking output for brightness control.
module disp_sr_par #(
  parameter int CHAINS     = 2,
  parameter int WIDTH      = 128,
  parameter int HALF       = 4,
  parameter int LAT_CYCLES = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tsc_1pps,
  input  logic                      tsc_1ppms,
  input  logic                      tsc_1ppus,
  input  logic [1:0]                upd_mode,
  input  logic [7:0]                brightness,
  input  logic [CHAINS*WIDTH-1:0]   disp_data,
  output logic                      disp_sclk,
  output logic                      disp_lat,
  output logic [CHAINS-1:0]         disp_sin,
  output logic                      disp_blank,
  output logic                      busy
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int LW = (LAT_CYCLES > 1) ? $clog2(LAT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  state_t                    state;
  logic [CHAINS*WIDTH-1:0]   shadow;
  logic [CHAINS*WIDTH-1:0]   last_sent;
  logic                      pending;
  logic [HW-1:0]             half_cnt;
  logic [BW-1:0]             bit_cnt;
  logic [LW-1:0]             lat_cnt;
  logic [7:0]                pwm_cnt;
  logic                      trigger;

  // Serial bit k of every chain, honouring the shift order.
  function automatic logic [CHAINS-1:0] pick_bits(input logic [CHAINS*WIDTH-1:0] frame,
                                                  input logic [BW-1:0] k);
    logic [CHAINS-1:0] b;
    int idx;
    idx = (MSB_FIRST != 0) ? (WIDTH - 1 - int'(k)) : int'(k);
    for (int c = 0; c < CHAINS; c++) begin
      b[c] = frame[c*WIDTH + idx];
    end
    return b;
  endfunction

  // Frame request for the selected update mode; while a frame is running the
  // data-change compare is made against the frame being sent, so data that is
  // already on its way never queues a duplicate frame.
  always_comb begin
    trigger = 1'b0;
    case (upd_mode)
      2'd0:    trigger = tsc_1pps;
      2'd1:    trigger = tsc_1ppms;
      2'd2:    trigger = (disp_data != (busy ? shadow : last_sent));
      default: trigger = 1'b0;
    endcase
  end

  // Frame sequencer: capture, shift every bit with a symmetric sclk, latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      disp_sclk <= 1'b0;
      disp_lat  <= 1'b0;
      disp_sin  <= '0;
      busy      <= 1'b0;
      pending   <= 1'b0;
      shadow    <= '0;
      last_sent <= '0;
      half_cnt  <= '0;
      bit_cnt   <= '0;
      lat_cnt   <= '0;
    end else begin
      if (state != IDLE) begin
        if (upd_mode == 2'd3) begin
          pending <= 1'b0;
        end else if (trigger) begin
          pending <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          disp_sclk <= 1'b0;
          disp_lat  <= 1'b0;
          if (upd_mode == 2'd3) begin
            pending <= 1'b0;
          end else if (trigger || pending) begin
            state   <= LOAD;
            busy    <= 1'b1;
            pending <= 1'b0;
            shadow  <= disp_data;
          end
        end
        LOAD: begin
          state    <= SHIFT_LO;
          half_cnt <= '0;
          bit_cnt  <= '0;
          disp_sin <= pick_bits(shadow, '0);
        end
        SHIFT_LO: begin
          if (half_cnt == HW'(HALF - 1)) begin
            state     <= SHIFT_HI;
            disp_sclk <= 1'b1;
            half_cnt  <= '0;
          end else begin
            half_cnt <= half_cnt + HW'(1);
          end
        end
        SHIFT_HI: begin
          if (half_cnt == HW'(HALF - 1)) begin
            half_cnt  <= '0;
            disp_sclk <= 1'b0;
            bit_cnt   <= bit_cnt + BW'(1);
            if (bit_cnt == BW'(WIDTH - 1)) begin
              state    <= LATCH;
              disp_lat <= 1'b1;
              lat_cnt  <= '0;
            end else begin
              state    <= SHIFT_LO;
              disp_sin <= pick_bits(shadow, bit_cnt + BW'(1));
            end
          end else begin
            half_cnt <= half_cnt + HW'(1);
          end
        end
        LATCH: begin
          if (lat_cnt == LW'(LAT_CYCLES - 1)) begin
            state     <= IDLE;
            disp_lat  <= 1'b0;
            busy      <= 1'b0;
            last_sent <= shadow;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          disp_sclk <= 1'b0;
          disp_lat  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Brightness PWM: counter advances on the microsecond strobe, blank while
  // the counter is at or above the brightness setting.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt    <= 8'd0;
      disp_blank <= 1'b1;
    end else begin
      if (tsc_1ppus) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
      disp_blank <= (pwm_cnt >= brightness);
    end
  end

endmodule

// File: tb/tb_disp_sr_par.sv
// tb_disp_sr_par: directed bench for disp_sr_par with an 8-bit, 2-chain
// configuration; a second instance shifts LSB first.
module tb_disp_sr_par;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tsc_1pps = 1'b0;
  logic        tsc_1ppms = 1'b0;
  logic        tsc_1ppus = 1'b0;
  logic [1:0]  upd_mode = 2'd3;
  logic [7:0]  brightness = 8'd128;
  logic [15:0] disp_data = 16'h0000;
  logic [15:0] lsb_data = 16'h0000;

  logic        disp_sclk, disp_lat, disp_blank, busy;
  logic [1:0]  disp_sin;
  logic        lsb_sclk, lsb_lat, lsb_blank, lsb_busy;
  logic [1:0]  lsb_sin;

  int checks = 0;
  int errors = 0;

  disp_sr_par #(.CHAINS(2), .WIDTH(8), .HALF(2), .LAT_CYCLES(3), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .tsc_1pps(tsc_1pps), .tsc_1ppms(tsc_1ppms), .tsc_1ppus(tsc_1ppus),
    .upd_mode(upd_mode), .brightness(brightness), .disp_data(disp_data),
    .disp_sclk(disp_sclk), .disp_lat(disp_lat), .disp_sin(disp_sin),
    .disp_blank(disp_blank), .busy(busy)
  );

  disp_sr_par #(.CHAINS(2), .WIDTH(8), .HALF(2), .LAT_CYCLES(3), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .tsc_1pps(tsc_1pps), .tsc_1ppms(tsc_1ppms), .tsc_1ppus(tsc_1ppus),
    .upd_mode(upd_mode), .brightness(brightness), .disp_data(lsb_data),
    .disp_sclk(lsb_sclk), .disp_lat(lsb_lat), .disp_sin(lsb_sin),
    .disp_blank(lsb_blank), .busy(lsb_busy)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Guard against a hung run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // One clock: inputs set now are consumed at the next edge, outputs sampled 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_pps();
    tsc_1pps = 1'b1;
    tick();
    tsc_1pps = 1'b0;
  endtask

  // Observe one frame from its LOAD cycle until busy drops
  task automatic capture(input int budget,
                         output logic [7:0] m0, output logic [7:0] m1,
                         output logic [7:0] l0, output logic [7:0] l1,
                         output int rises, output int lat_cyc,
                         output int busy_cyc, output int glitches);
    logic       prev_sclk, prev_lsclk;
    logic [1:0] prev_sin;
    m0 = '0; m1 = '0; l0 = '0; l1 = '0;
    rises = 0; lat_cyc = 0; busy_cyc = 0; glitches = 0;
    prev_sclk = 1'b0; prev_lsclk = 1'b0; prev_sin = disp_sin;
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      busy_cyc++;
      if (disp_lat) lat_cyc++;
      if (disp_sclk && !prev_sclk) begin
        rises++;
        m0 = {m0[6:0], disp_sin[0]};
        m1 = {m1[6:0], disp_sin[1]};
        if (disp_sin != prev_sin) glitches++;
      end else if (disp_sclk && disp_sin != prev_sin) begin
        glitches++;
      end
      if (lsb_sclk && !prev_lsclk) begin
        l0 = {l0[6:0], lsb_sin[0]};
        l1 = {l1[6:0], lsb_sin[1]};
      end
      prev_sclk = disp_sclk; prev_lsclk = lsb_sclk; prev_sin = disp_sin;
      tick();
    end
  endtask

  // Count latch pulses over n cycles
  task automatic count_lat(input int n, output int pulses);
    logic prev;
    pulses = 0;
    prev = disp_lat;
    for (int i = 0; i < n; i++) begin
      tick();
      if (disp_lat && !prev) pulses++;
      prev = disp_lat;
    end
  endtask

  task automatic test_reset();
    int busy_seen;
    rst = 1'b1; upd_mode = 2'd3; brightness = 8'd128; disp_data = 16'hA55A;
    tick(); tick();
    checks++; if (disp_sclk !== 1'b0) begin errors++; $display("[TB] FAIL reset_sclk: got %b expected 0", disp_sclk); end
    checks++; if (disp_lat !== 1'b0) begin errors++; $display("[TB] FAIL reset_lat: got %b expected 0", disp_lat); end
    checks++; if (disp_sin !== 2'b00) begin errors++; $display("[TB] FAIL reset_sin: got %b expected 00", disp_sin); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (disp_blank !== 1'b1) begin errors++; $display("[TB] FAIL reset_blank: got %b expected 1", disp_blank); end
    rst = 1'b0;
    tsc_1pps = 1'b1; tsc_1ppms = 1'b1;
    tick();
    tsc_1pps = 1'b0; tsc_1ppms = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) busy_seen++;
      tick();
    end
    checks++; if (busy_seen != 0) begin errors++; $display("[TB] FAIL mode3_disabled: busy cycles %0d expected 0", busy_seen); end
  endtask

  task automatic test_mode0_frame();
    logic [7:0] m0, m1, l0, l1;
    int rises, lat_cyc, busy_cyc, glitches;
    reset_dut();
    upd_mode = 2'd0; disp_data = 16'hA55A;
    pulse_pps();
    disp_data = 16'h0000;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL m0_busy_rise: got %b expected 1", busy); end
    capture(80, m0, m1, l0, l1, rises, lat_cyc, busy_cyc, glitches);
    checks++; if (m0 !== 8'h5A) begin errors++; $display("[TB] FAIL m0_chain0: got %h expected 5a", m0); end
    checks++; if (m1 !== 8'hA5) begin errors++; $display("[TB] FAIL m0_chain1: got %h expected a5", m1); end
    checks++; if (rises != 8) begin errors++; $display("[TB] FAIL m0_rises: got %0d expected 8", rises); end
    checks++; if (lat_cyc != 3) begin errors++; $display("[TB] FAIL m0_lat_len: got %0d expected 3", lat_cyc); end
    checks++; if (busy_cyc != 36) begin errors++; $display("[TB] FAIL m0_busy_len: got %0d expected 36", busy_cyc); end
    checks++; if (glitches != 0) begin errors++; $display("[TB] FAIL m0_sin_stable: got %0d changes expected 0", glitches); end
  endtask

  task automatic test_mode1_pending();
    logic prev_busy, prev_lat;
    int frames, lats, gap_err, busy_total, idle_len, first_rise;
    reset_dut();
    upd_mode = 2'd1;
    prev_busy = 1'b0; prev_lat = 1'b0;
    frames = 0; lats = 0; gap_err = 0; busy_total = 0; idle_len = 0; first_rise = -1;
    for (int i = 0; i < 220; i++) begin
      tsc_1ppms = ((i % 20) == 0) && (i <= 100);
      tick();
      if (busy && !prev_busy) begin
        frames++;
        if (first_rise < 0) first_rise = i;
        if (frames > 1 && idle_len != 1) gap_err++;
      end
      if (!busy) idle_len++; else idle_len = 0;
      if (busy) busy_total++;
      if (disp_lat && !prev_lat) lats++;
      prev_busy = busy; prev_lat = disp_lat;
    end
    tsc_1ppms = 1'b0;
    checks++; if (first_rise != 0) begin errors++; $display("[TB] FAIL m1_first_start: got %0d expected 0", first_rise); end
    checks++; if (frames != 4) begin errors++; $display("[TB] FAIL m1_frames: got %0d expected 4", frames); end
    checks++; if (lats != 4) begin errors++; $display("[TB] FAIL m1_lat_pulses: got %0d expected 4", lats); end
    checks++; if (gap_err != 0) begin errors++; $display("[TB] FAIL m1_idle_gap: got %0d bad gaps expected 0", gap_err); end
    checks++; if (busy_total != 144) begin errors++; $display("[TB] FAIL m1_busy_total: got %0d expected 144", busy_total); end
  endtask

  task automatic test_mode2_change();
    int p;
    disp_data = 16'h0000;
    reset_dut();
    upd_mode = 2'd2;
    count_lat(20, p);
    checks++; if (p != 0) begin errors++; $display("[TB] FAIL m2_no_change: got %0d expected 0", p); end
    disp_data = 16'h00FF;
    count_lat(80, p);
    checks++; if (p != 1) begin errors++; $display("[TB] FAIL m2_first_change: got %0d expected 1", p); end
    count_lat(80, p);
    checks++; if (p != 0) begin errors++; $display("[TB] FAIL m2_hold: got %0d expected 0", p); end
    disp_data = 16'h00FF;
    count_lat(80, p);
    checks++; if (p != 0) begin errors++; $display("[TB] FAIL m2_rewrite_same: got %0d expected 0", p); end
    disp_data = 16'h0100;
    count_lat(80, p);
    checks++; if (p != 1) begin errors++; $display("[TB] FAIL m2_second_change: got %0d expected 1", p); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] m0, m1, l0, l1;
    int rises, lat_cyc, busy_cyc, glitches, p;
    logic prev_sclk;
    reset_dut();
    upd_mode = 2'd0; disp_data = 16'hA55A;
    pulse_pps();
    rises = 0; prev_sclk = disp_sclk;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (disp_sclk && !prev_sclk) rises++;
      prev_sclk = disp_sclk;
      if (rises == 5) break;
    end
    checks++; if (rises != 5) begin errors++; $display("[TB] FAIL rm_reach_bit4: got %0d rises expected 5", rises); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({disp_sclk, disp_lat, disp_sin, busy, disp_blank} !== 6'b000001) begin
      errors++; $display("[TB] FAIL rm_outputs: got %b expected 000001", {disp_sclk, disp_lat, disp_sin, busy, disp_blank});
    end
    count_lat(60, p);
    checks++; if (p != 0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rm_no_latch: got %0d pulses busy %b expected 0 and 0", p, busy); end
    pulse_pps();
    capture(80, m0, m1, l0, l1, rises, lat_cyc, busy_cyc, glitches);
    checks++; if ({m0, m1} !== 16'h5AA5) begin errors++; $display("[TB] FAIL rm_refill_bits: got %h expected 5aa5", {m0, m1}); end
    checks++; if (rises != 8 || lat_cyc != 3 || busy_cyc != 36) begin
      errors++; $display("[TB] FAIL rm_refill_frame: got rises %0d lat %0d busy %0d expected 8 3 36", rises, lat_cyc, busy_cyc);
    end
  endtask

  task automatic test_pwm();
    logic [7:0] bvals [3];
    int         expv  [3];
    int         cnt;
    bvals[0] = 8'd0;   expv[0] = 512;
    bvals[1] = 8'd64;  expv[1] = 384;
    bvals[2] = 8'd255; expv[2] = 2;
    upd_mode = 2'd3;
    for (int k = 0; k < 3; k++) begin
      brightness = bvals[k];
      cnt = 0;
      for (int i = 0; i < 516; i++) begin
        tsc_1ppus = (i % 2) == 1;
        tick();
        if (i >= 4 && disp_blank) cnt++;
      end
      tsc_1ppus = 1'b0;
      checks++; if (cnt != expv[k]) begin errors++; $display("[TB] FAIL pwm_b%0d: got %0d blank of 512 expected %0d", bvals[k], cnt, expv[k]); end
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] m0, m1, l0, l1;
    int rises, lat_cyc, busy_cyc, glitches;
    reset_dut();
    upd_mode = 2'd0; disp_data = 16'hA55A; lsb_data = 16'h0001;
    pulse_pps();
    capture(80, m0, m1, l0, l1, rises, lat_cyc, busy_cyc, glitches);
    checks++; if (l0 !== 8'h80) begin errors++; $display("[TB] FAIL lsb_chain0: got %h expected 80", l0); end
    checks++; if (l1 !== 8'h00) begin errors++; $display("[TB] FAIL lsb_chain1: got %h expected 00", l1); end
    checks++; if (lsb_busy !== 1'b0 || lsb_lat !== 1'b0) begin errors++; $display("[TB] FAIL lsb_end: got busy %b lat %b expected 0 0", lsb_busy, lsb_lat); end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_mode0_frame();
    test_mode1_pending();
    test_mode2_change();
    test_reset_mid_frame();
    test_pwm();
    test_lsb_first();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
